// File: rtl/parity_uart_tx.sv
// UART-style serial transmitter: start, LSB-first data, parity, stop.
// Parity is accumulated as the data bits leave the shift register.
module parity_uart_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYC    = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              par_out
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cyc_cnt;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_nxt;
    logic              acc;
    logic              acc_nxt;
    logic              bit_end;

    assign din_rdy = (state == S_IDLE);
    assign bit_end = (cyc_cnt == CYC_LAST);
    assign sh_nxt  = shreg >> 1;
    assign acc_nxt = acc ^ shreg[0];

    // tx_out is registered, so each state loads the value of the next bit
    // on the edge that ends the current one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            tx_out  <= 1'b1;
            tx_busy <= 1'b0;
            par_out <= 1'b0;
        end else begin
            if (state == S_IDLE || bit_end) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end

            unique case (state)
                S_IDLE: begin
                    tx_out <= 1'b1;
                    if (din_vld) begin
                        shreg   <= din;
                        acc     <= 1'b0;
                        bit_idx <= '0;
                        state   <= S_START;
                        tx_out  <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state  <= S_DATA;
                        tx_out <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        acc   <= acc_nxt;
                        shreg <= sh_nxt;
                        if (bit_idx == IDX_LAST) begin
                            state   <= S_PARITY;
                            tx_out  <= acc_nxt ^ ODD_PARITY;
                            par_out <= acc_nxt ^ ODD_PARITY;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            tx_out  <= sh_nxt[0];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state  <= S_STOP;
                        tx_out <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        state   <= S_IDLE;
                        tx_out  <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_uart_tx.sv
// Directed bench for parity_uart_tx: three instances cover
// even/BIT_CYC=4, odd/BIT_CYC=4 and even/BIT_CYC=1.
module tb_parity_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din  [3];
    logic       vld  [3];
    logic       rdy  [3];
    logic       tx   [3];
    logic       busy [3];
    logic       par  [3];

    int n_chk;
    int n_fail;

    parity_uart_tx #(.DATA_W(8), .BIT_CYC(4), .ODD_PARITY(1'b0)) u_even (
        .sys_clk(clk), .sys_rst_n(rst_n), .din(din[0]), .din_vld(vld[0]),
        .din_rdy(rdy[0]), .tx_out(tx[0]), .tx_busy(busy[0]), .par_out(par[0])
    );

    parity_uart_tx #(.DATA_W(8), .BIT_CYC(4), .ODD_PARITY(1'b1)) u_odd (
        .sys_clk(clk), .sys_rst_n(rst_n), .din(din[1]), .din_vld(vld[1]),
        .din_rdy(rdy[1]), .tx_out(tx[1]), .tx_busy(busy[1]), .par_out(par[1])
    );

    parity_uart_tx #(.DATA_W(8), .BIT_CYC(1), .ODD_PARITY(1'b0)) u_fast (
        .sys_clk(clk), .sys_rst_n(rst_n), .din(din[2]), .din_vld(vld[2]),
        .din_rdy(rdy[2]), .tx_out(tx[2]), .tx_busy(busy[2]), .par_out(par[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         which;
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic int bc_of(input int w);
        return (w == 2) ? 1 : 4;
    endfunction

    // Sends one word on instance w and checks every cycle of the frame.
    // pre: word already presented; hold: keep din_vld high and load nxt;
    // scr: scramble din every cycle with din_vld high.
    task automatic send(input int w, input logic [7:0] data,
                        input logic exp_par, input bit pre,
                        input bit hold, input logic [7:0] nxt,
                        input bit scr);
        int bc;
        int flen;
        logic [10:0] fr;
        bit got;
        bc   = bc_of(w);
        flen = 11 * bc;
        fr   = {1'b1, exp_par, data, 1'b0};
        if (!pre) begin
            got = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rdy[w]) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("rdy_wait w%0d", w), got, 1'b1);
            din[w] = data;
            vld[w] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) din[w] = nxt;
        else if (!scr) vld[w] = 1'b0;
        for (int k = 0; k < flen; k++) begin
            chk($sformatf("tx w%0d %02h c%0d", w, data, k), tx[w], fr[k / bc]);
            chk($sformatf("busy w%0d %02h c%0d", w, data, k), busy[w], 1'b1);
            chk($sformatf("rdy w%0d %02h c%0d", w, data, k), rdy[w], 1'b0);
            if (scr) din[w] = 8'($urandom);
            @(negedge clk);
        end
        chk($sformatf("idle_tx w%0d %02h", w, data), tx[w], 1'b1);
        chk($sformatf("idle_busy w%0d %02h", w, data), busy[w], 1'b0);
        chk($sformatf("idle_rdy w%0d %02h", w, data), rdy[w], 1'b1);
        chk($sformatf("par_out w%0d %02h", w, data), par[w], exp_par);
        if (!hold) vld[w] = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            vld[i] = 1'b0;
        end

        vecs[0] = '{0, 8'hA5, 1'b0};
        vecs[1] = '{0, 8'h07, 1'b1};
        vecs[2] = '{1, 8'h07, 1'b0};
        vecs[3] = '{1, 8'hA5, 1'b1};
        vecs[4] = '{2, 8'h81, 1'b0};
        vecs[5] = '{2, 8'h07, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx w%0d", i), tx[i], 1'b1);
            chk($sformatf("rst_busy w%0d", i), busy[i], 1'b0);
            chk($sformatf("rst_par w%0d", i), par[i], 1'b0);
            chk($sformatf("rst_rdy w%0d", i), rdy[i], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with din_vld low: line stays high, no frame starts.
        repeat (5) @(negedge clk);
        chk("idle_hold_tx", tx[0], 1'b1);
        chk("idle_hold_busy", busy[0], 1'b0);

        foreach (vecs[i])
            send(vecs[i].which, vecs[i].data, vecs[i].exp_par,
                 1'b0, 1'b0, 8'h00, 1'b0);

        // Back-to-back with din_vld held: one idle cycle between frames.
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Leave par_out at 1 so the reset clear is observable.
        send(0, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset during data bit 3 of 0x5A.
        @(negedge clk);
        din[0] = 8'h5A;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_rst_busy", busy[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx[0], 1'b1);
        chk("async_rst_busy", busy[0], 1'b0);
        chk("async_rst_par", par[0], 1'b0);
        chk("async_rst_rdy", rdy[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tx", tx[0], 1'b1);
        chk("post_rst_busy", busy[0], 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // din scrambled during the frame: only the captured word is sent.
        send(0, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_extra_hs_busy", busy[0], 1'b0);
        chk("no_extra_hs_tx", tx[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_uart_tx.md
Name: parity_uart_tx

Overview:
- Serial transmitter that takes a parallel word over a valid/ready handshake and shifts out a UART-style frame: start, data LSB-first, parity, stop.
- The parity bit comes from a running XOR over the data bits as they shift out.
- Sits downstream of the combinational XOR sample logic and drives a single-wire serial line, e.g. a pin or a loopback checker.

Parameters:
- DATA_W, 8: data bits per frame; legal range 1..32.
- BIT_CYC, 4: sys_clk cycles each serial bit is held; legal range >=1.
- ODD_PARITY, 0: 0 selects even parity (parity = XOR of data bits); 1 selects odd parity (inverted XOR).

Ports:
- sys_clk, input, 1: single clock; all state updates on the rising edge.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- din, input, DATA_W: word to transmit; sampled only on handshake.
- din_vld, input, 1: din is valid.
- din_rdy, output, 1: block can accept a word. Combinational; equals (state==IDLE).
- tx_out, output, 1: serial line, registered; idles high.
- tx_busy, output, 1: registered; high from the START state through the end of the STOP state.
- par_out, output, 1: registered; parity bit of the most recent frame.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - state=IDLE, tx_out=1, tx_busy=0, par_out=0.
  - Bit counter, cycle counter, shift register and parity accumulator all cleared.
  - Any partial frame is abandoned and is not resumed.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE:
  - tx_out=1, din_rdy=1.
  - Handshake fires on the rising edge where din_vld=1 and din_rdy=1.
  - On that edge: din loads into the shift register, parity accumulator clears, state goes to START.
  - With din_vld=0, the block stays in IDLE indefinitely.
- Bit timing:
  - Each of START, each DATA bit, PARITY and STOP holds tx_out for exactly BIT_CYC cycles.
  - A cycle counter counts 0..BIT_CYC-1; its width is clog2(BIT_CYC), minimum 1.
  - BIT_CYC=1 must work: one cycle per bit.
- START: tx_out=0 for BIT_CYC cycles.
- DATA:
  - tx_out = shift register bit 0.
  - At the end of each bit period: accumulator <= accumulator XOR bit0, shift register shifts right by 1, bit index increments.
  - After bit index DATA_W-1 completes, go to PARITY.
- PARITY:
  - tx_out = accumulator XOR ODD_PARITY, i.e. XOR of all DATA_W data bits, inverted when odd parity is selected.
  - par_out loads this value on the edge entering PARITY and holds it until the next frame's PARITY entry.
- STOP: tx_out=1 for BIT_CYC cycles, then IDLE.
- Timing:
  - Frame length is (DATA_W+3)*BIT_CYC cycles, counted from the first START cycle to the last STOP cycle inclusive.
  - tx_busy rises on the first START cycle and falls on the first IDLE cycle.
  - tx_out changes only on bit boundaries: no glitches, no mid-bit changes.
- Back-to-back words: din_vld held high with new data gives at least one IDLE cycle (tx_out=1) between a STOP and the next START.
- din and din_vld are ignored while busy (din_rdy=0). Changes to din after the handshake do not affect the frame in flight.
- Simultaneous events: reset wins over everything. A handshake in the same cycle as reset deassertion is not accepted; din_rdy only takes effect from the first clocked IDLE cycle.

Test Plan:
- Reset, then DATA_W=8, BIT_CYC=4, even parity; send 0xA5.
  - tx_out: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then parity 0, then stop 1.
  - Frame lasts 44 cycles; par_out=0; tx_busy high for exactly 44 cycles.
- Send 0x07 with even parity: parity bit 1 and par_out=1. Same word with ODD_PARITY=1: parity bit 0 and par_out=0.
- Send 0x00 then 0xFF back-to-back with din_vld held high:
  - Both parity bits are 0.
  - Exactly 1 idle-high cycle separates the frames.
  - din_rdy=0 throughout each frame.
- BIT_CYC=1, send 0x81: frame is 11 cycles: 0, 1,0,0,0,0,0,0,1, parity 0, stop 1.
- Assert sys_rst_n=0 during data bit 3 of 0x5A:
  - tx_out=1, tx_busy=0, par_out=0 immediately, before the next clock edge.
  - After release, a new word 0x3C transmits as a complete, correct frame with parity 0.
- Change din every cycle during a frame with din_vld=1: the transmitted bits match only the word captured at the handshake, and no extra handshake occurs.
